// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX arbiter
//
// Purpose: state encoding and width/limit constants used by uart_tx_arbiter.
// Ports:   none (package).

package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of the burst and idle counters.
  localparam int ARB_CNT_W = 8;

  // Largest requester count the arbiter supports.
  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority encoder
//
// Purpose: finds the first set bit of req scanning upward from base, wrapping
//          at NUM_REQ (which need not be a power of two).
// Ports:
//   req   in  NUM_REQ  request vector
//   base  in  IDX_W    first position examined (highest priority)
//   found out 1        at least one request is set
//   index out IDX_W    position of the winning request (0 when none)

module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down to offset 0 so that the candidate
  // closest to base is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, base} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter for the UART TX FIFO write port
//
// Purpose: shares the TX FIFO write port among NUM_REQ byte streams. A grant
//          lasts for one frame (ended by req_last), at most MAX_BURST bytes,
//          or until the grantee has been idle for IDLE_TIMEOUT cycles.
// Ports:
//   clk         in  1          clock
//   reset       in  1          synchronous active-high reset
//   enable      in  1          allow new grants
//   req_valid   in  NUM_REQ    byte available per requester
//   req_data    in  NUM_REQ*8  byte per requester (requester i at [8i+7:8i])
//   req_last    in  NUM_REQ    byte ends its frame
//   req_ready   out NUM_REQ    byte accepted this cycle (one-hot or zero)
//   fifo_wen    out 1          TX FIFO write strobe
//   fifo_wdata  out 8          TX FIFO write data
//   fifo_full   in  1          TX FIFO full
//   busy        out 1          a grant is held
//   grant_id    out ID_W       current or most recent grantee
//   revoked     out 1          pulse: previous grant ended by idle timeout

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 16,
  parameter  int IDLE_TIMEOUT = 32,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   fifo_wen,
  output logic [7:0]             fifo_wdata,
  input  logic                   fifo_full,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   revoked
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_chk_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_max_burst
    $error("uart_tx_arbiter: MAX_BURST must be in 1..255");
  end
  if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_chk_idle_timeout
    $error("uart_tx_arbiter: IDLE_TIMEOUT must be in 1..255");
  end

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      last_ptr, last_ptr_nxt;
  logic [ID_W-1:0]      grant_nxt;
  logic [ARB_CNT_W-1:0] burst_cnt, burst_nxt;
  logic [ARB_CNT_W-1:0] idle_cnt, idle_nxt;
  logic                 revoked_nxt;

  logic [ID_W-1:0]      start_ptr;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;

  logic                 cur_valid;
  logic                 cur_last;
  logic [7:0]           cur_data;
  logic                 xfer;
  logic                 rel_last;
  logic                 rel_burst;
  logic                 rel_timeout;

  // Arbitration starts one past the previous grantee. NUM_REQ may not be a
  // power of two, so the wrap is an explicit compare rather than overflow.
  assign start_ptr = (last_ptr == ID_W'(NUM_REQ - 1)) ? '0 : last_ptr + ID_W'(1);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .req   (req_valid),
    .base  (start_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_data  = req_data[{grant_id, 3'b000} +: 8];

  // Gating with reset keeps the FIFO from seeing a write in the cycle the
  // grant is being torn down.
  assign xfer = (state == GRANT) && cur_valid && !fifo_full && !reset;

  assign rel_last    = xfer && cur_last;
  assign rel_burst   = xfer && (burst_cnt == ARB_CNT_W'(MAX_BURST - 1));
  assign rel_timeout = (state == GRANT) && !cur_valid &&
                       (idle_cnt == ARB_CNT_W'(IDLE_TIMEOUT - 1));

  assign busy       = (state == GRANT);
  assign fifo_wen   = xfer;
  assign fifo_wdata = xfer ? cur_data : 8'h00;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_ptr_nxt = last_ptr;
    grant_nxt    = grant_id;
    burst_nxt    = burst_cnt;
    idle_nxt     = idle_cnt;
    revoked_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pick_found) begin
          grant_nxt = pick_idx;
          burst_nxt = '0;
          idle_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_nxt = burst_cnt + ARB_CNT_W'(1);
          idle_nxt  = '0;
        end else if (!cur_valid && (idle_cnt != '1)) begin
          // Only an absent grantee ages; a stall from fifo_full holds the count.
          idle_nxt = idle_cnt + ARB_CNT_W'(1);
        end
        if (rel_last || rel_burst || rel_timeout) begin
          state_nxt    = IDLE;
          last_ptr_nxt = grant_id;
        end
        revoked_nxt = rel_timeout;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ptr  <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      revoked   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_ptr  <= last_ptr_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
      revoked   <= revoked_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
//
// Purpose: drives queued byte frames on four requesters, logs every FIFO
//          write with its cycle and grantee, and compares against
//          hand-computed expected transfer tables.
// Ports:   none (top-level bench).

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        revoked;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .MAX_BURST    (16),
    .IDLE_TIMEOUT (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .grant_id   (grant_id),
    .revoked    (revoked)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int c0 = 0;
  int rdy_seen = 0;

  logic rst_v = 1'b1;
  logic en_v = 1'b1;
  logic full_v = 1'b0;

  logic [8:0] rq [4][$];

  int log_d[$];
  int log_c[$];
  int log_g[$];
  int rev_c[$];
  int exp_d[$];
  int exp_o[$];
  int exp_g[$];

  int busy_s, wen_s, ready_s, revoked_s, grant_s;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic exp_x(input int d, input int o, input int g);
    exp_d.push_back(d);
    exp_o.push_back(o);
    exp_g.push_back(g);
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled at the falling edge, accepted bytes are retired from the queues.
  task automatic tick();
    logic [8:0] h;
    @(posedge clk);
    cyc++;
    #1;
    reset     = rst_v;
    enable    = en_v;
    fifo_full = full_v;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    @(negedge clk);
    busy_s    = int'(busy);
    wen_s     = int'(fifo_wen);
    ready_s   = int'(req_ready);
    revoked_s = int'(revoked);
    grant_s   = int'(grant_id);
    if (fifo_wen) begin
      log_d.push_back(int'(fifo_wdata));
      log_c.push_back(cyc);
      log_g.push_back(int'(grant_id));
    end
    if (revoked) rev_c.push_back(cyc);
    if (req_ready != 4'b0) rdy_seen++;
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) void'(rq[i].pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic new_test();
    log_d.delete(); log_c.delete(); log_g.delete(); rev_c.delete();
    exp_d.delete(); exp_o.delete(); exp_g.delete();
    c0 = cyc;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) rq[i].delete();
    full_v = 1'b0;
    en_v   = 1'b1;
    rst_v  = 1'b1;
    tick();
    rst_v  = 1'b0;
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, log_d.size(), exp_d.size());
    for (int k = 0; k < exp_d.size(); k++) begin
      check_eq($sformatf("%s_data%0d", tag, k), (k < log_d.size()) ? log_d[k] : -1, exp_d[k]);
      check_eq($sformatf("%s_cyc%0d", tag, k), (k < log_c.size()) ? log_c[k] - c0 : -1, exp_o[k]);
      check_eq($sformatf("%s_gnt%0d", tag, k), (k < log_g.size()) ? log_g[k] : -1, exp_g[k]);
    end
  endtask

  initial begin
    // Reset state
    ticks(2);
    check_eq("rst_busy", busy_s, 0);
    check_eq("rst_grant", grant_s, 0);
    check_eq("rst_revoked", revoked_s, 0);
    check_eq("rst_wen", wen_s, 0);
    check_eq("rst_ready", ready_s, 0);
    rst_v = 1'b0;

    // Single requester, 4-byte frame
    new_test();
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 0); push(0, 8'h44, 1);
    for (int k = 0; k < 4; k++) exp_x(8'h41 + k, 2 + k, 0);
    ticks(5);
    check_eq("t1_busy_last", busy_s, 1);
    tick();
    check_eq("t1_busy_fall", busy_s, 0);
    check_eq("t1_grant", grant_s, 0);
    check_log("t1");

    // Fairness: three requesters, two 2-byte frames each
    do_reset();
    new_test();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 3; r++) begin
        push(r, 8'(8'h10 * (r + 1) + 2 * f), 0);
        push(r, 8'(8'h10 * (r + 1) + 2 * f + 1), 1);
      end
    end
    for (int k = 0; k < 12; k++) begin
      exp_x(8'h10 * ((k / 2) % 3 + 1) + 2 * (k / 6) + (k % 2), 2 + 3 * (k / 2) + (k % 2), (k / 2) % 3);
    end
    ticks(20);
    check_log("t2");
    check_eq("t2_busy_end", busy_s, 0);

    // Burst cap: 20 unterminated bytes from req 3 against a frame from req 1
    do_reset();
    new_test();
    for (int k = 0; k < 20; k++) push(3, 8'(8'h60 + k), 0);
    tick();
    push(1, 8'hA0, 0); push(1, 8'hA1, 1);
    for (int k = 0; k < 16; k++) exp_x(8'h60 + k, 2 + k, 3);
    exp_x(8'hA0, 19, 1);
    exp_x(8'hA1, 20, 1);
    for (int k = 16; k < 20; k++) exp_x(8'h60 + k, 6 + k, 3);
    ticks(26);
    check_log("t3");

    // Back-pressure: 50 full cycles mid-frame
    do_reset();
    new_test();
    for (int k = 0; k < 6; k++) push(0, 8'(8'h80 + k), k == 5);
    ticks(3);
    full_v = 1'b1;
    rdy_seen = 0;
    ticks(50);
    check_eq("t4_stall_ready", rdy_seen, 0);
    check_eq("t4_stall_revoked", rev_c.size(), 0);
    check_eq("t4_stall_busy", busy_s, 1);
    check_eq("t4_stall_count", log_d.size(), 2);
    full_v = 1'b0;
    ticks(6);
    exp_x(8'h80, 2, 0); exp_x(8'h81, 3, 0);
    for (int k = 2; k < 6; k++) exp_x(8'h80 + k, 52 + k, 0);
    check_log("t4");
    check_eq("t4_revoked", rev_c.size(), 0);

    // Idle timeout
    do_reset();
    new_test();
    push(2, 8'h55, 0);
    tick();
    push(1, 8'h90, 0); push(1, 8'h91, 1);
    ticks(39);
    exp_x(8'h55, 2, 2);
    exp_x(8'h90, 36, 1);
    exp_x(8'h91, 37, 1);
    check_log("t5");
    check_eq("t5_rev_count", rev_c.size(), 1);
    check_eq("t5_rev_cyc", (rev_c.size() > 0) ? rev_c[0] - c0 : -1, 35);

    // Reset mid-frame
    do_reset();
    new_test();
    push(1, 8'hB0, 0); push(1, 8'hB1, 0); push(1, 8'hB2, 0); push(1, 8'hB3, 1);
    ticks(2);
    push(0, 8'hC0, 0); push(0, 8'hC1, 1);
    tick();
    rst_v = 1'b1;
    tick();
    check_eq("t6_rst_wen", wen_s, 0);
    check_eq("t6_rst_ready", ready_s, 0);
    rst_v = 1'b0;
    tick();
    check_eq("t6_post_wen", wen_s, 0);
    check_eq("t6_post_busy", busy_s, 0);
    ticks(6);
    exp_x(8'hB0, 2, 1); exp_x(8'hB1, 3, 1);
    exp_x(8'hC0, 6, 0); exp_x(8'hC1, 7, 0);
    exp_x(8'hB2, 9, 1); exp_x(8'hB3, 10, 1);
    check_log("t6");

    // Enable low: no grant; enable dropped mid-grant: frame completes
    en_v = 1'b0;
    new_test();
    push(2, 8'hD0, 1);
    ticks(5);
    check_eq("t7_dis_busy", busy_s, 0);
    check_eq("t7_dis_count", log_d.size(), 0);
    en_v = 1'b1;
    ticks(3);
    push(3, 8'hE0, 0); push(3, 8'hE1, 0); push(3, 8'hE2, 1);
    push(0, 8'hF0, 1);
    ticks(2);
    en_v = 1'b0;
    ticks(6);
    exp_x(8'hD0, 7, 2);
    exp_x(8'hE0, 10, 3); exp_x(8'hE1, 11, 3); exp_x(8'hE2, 12, 3);
    check_log("t7");
    check_eq("t7_end_busy", busy_s, 0);
    check_eq("t7_pending", rq[0].size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
